tmr_xor_state_reg: RTL and testbench

//  Parametrised triple-modular-redundant XOR-accumulate state register: WIDTH-bit next generation of the single-bit TMR toggle FSM.

---
 rtl/tmr_xor_state_reg.sv | 117 +++++++++++
 tb/tb_tmr_xor_state_reg.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/tmr_xor_state_reg.sv
// rtl/tmr_xor_state_reg.sv - triple-modular-redundant XOR-accumulate state register
// Three self-scrubbing state copies, bitwise majority vote, mismatch flags and saturating upset counter.

module tmr_domain_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] nxt,
  input  logic [WIDTH-1:0] inj,
  output logic [WIDTH-1:0] q
);

  // Injection is gated by reset so a reset always lands every copy at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      q <= nxt ^ inj;
    end
  end

endmodule

module tmr_xor_state_reg #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 load,
  input  logic [WIDTH-1:0]     din,
  input  logic [WIDTH-1:0]     inj_a,
  input  logic [WIDTH-1:0]     inj_b,
  input  logic [WIDTH-1:0]     inj_c,
  input  logic                 err_clr,
  output logic [WIDTH-1:0]     dout,
  output logic [2:0]           err_dom,
  output logic                 err_multi,
  output logic [2:0]           err_sticky,
  output logic [CNT_WIDTH-1:0] err_cnt
);

  logic [WIDTH-1:0] st_a;
  logic [WIDTH-1:0] st_b;
  logic [WIDTH-1:0] st_c;
  logic [WIDTH-1:0] voted;
  logic [WIDTH-1:0] nxt;

  // One instance per domain keeps the three register sets structurally separate.
  tmr_domain_reg #(.WIDTH(WIDTH)) u_dom_a (
    .clk (clk),
    .rst (rst),
    .nxt (nxt),
    .inj (inj_a),
    .q   (st_a)
  );

  tmr_domain_reg #(.WIDTH(WIDTH)) u_dom_b (
    .clk (clk),
    .rst (rst),
    .nxt (nxt),
    .inj (inj_b),
    .q   (st_b)
  );

  tmr_domain_reg #(.WIDTH(WIDTH)) u_dom_c (
    .clk (clk),
    .rst (rst),
    .nxt (nxt),
    .inj (inj_c),
    .q   (st_c)
  );

  always_comb begin
    voted = (st_a & st_b) | (st_b & st_c) | (st_a & st_c);
  end

  // Next state always derives from the voted value, so holding also scrubs.
  always_comb begin
    nxt = voted;
    if (load) begin
      nxt = din;
    end else if (en) begin
      nxt = voted ^ din;
    end
  end

  always_comb begin
    err_dom[0] = |(st_a ^ voted);
    err_dom[1] = |(st_b ^ voted);
    err_dom[2] = |(st_c ^ voted);
    err_multi  = (err_dom[0] & err_dom[1]) | (err_dom[1] & err_dom[2]) |
                 (err_dom[0] & err_dom[2]);
  end

  assign dout = voted;

  always_ff @(posedge clk) begin
    if (rst || err_clr) begin
      err_sticky <= '0;
    end else begin
      err_sticky <= err_sticky | err_dom;
    end
  end

  // Saturating count of mismatch cycles; clear wins over increment.
  always_ff @(posedge clk) begin
    if (rst || err_clr) begin
      err_cnt <= '0;
    end else if ((|err_dom) && (err_cnt != {CNT_WIDTH{1'b1}})) begin
      err_cnt <= err_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_tmr_xor_state_reg.sv
// tb/tb_tmr_xor_state_reg.sv - scoreboard bench for tmr_xor_state_reg
// Driver queues hand-computed expectations; monitor pops one per cycle after the edge.

module tb_tmr_xor_state_reg;

  typedef struct {
    logic [7:0] dout;
    logic [2:0] dom;
    logic       multi;
    logic [2:0] sticky;
    logic [1:0] cnt;
    int         step;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       en;
  logic       load;
  logic [7:0] din;
  logic [7:0] inj_a;
  logic [7:0] inj_b;
  logic [7:0] inj_c;
  logic       err_clr;
  logic [7:0] dout;
  logic [2:0] err_dom;
  logic       err_multi;
  logic [2:0] err_sticky;
  logic [1:0] err_cnt;

  exp_t exp_q[$];
  int   errors;
  int   checks;
  int   step_no;

  tmr_xor_state_reg #(.WIDTH(8), .CNT_WIDTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load       (load),
    .din        (din),
    .inj_a      (inj_a),
    .inj_b      (inj_b),
    .inj_c      (inj_c),
    .err_clr    (err_clr),
    .dout       (dout),
    .err_dom    (err_dom),
    .err_multi  (err_multi),
    .err_sticky (err_sticky),
    .err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int step, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL step %0d %s: got %h expected %h", step, name, act, req);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the following edge.
  task automatic step(input logic r, input logic e, input logic l, input logic [7:0] d,
                      input logic [7:0] ia, input logic [7:0] ib, input logic [7:0] ic,
                      input logic c, input logic [7:0] x_dout, input logic [2:0] x_dom,
                      input logic x_multi, input logic [2:0] x_sticky, input logic [1:0] x_cnt);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; load = l; din = d;
    inj_a = ia; inj_b = ib; inj_c = ic; err_clr = c;
    step_no++;
    x.dout = x_dout; x.dom = x_dom; x.multi = x_multi;
    x.sticky = x_sticky; x.cnt = x_cnt; x.step = step_no;
    exp_q.push_back(x);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("dout",       x.step, dout,               x.dout);
        chk("err_dom",    x.step, {5'd0, err_dom},    {5'd0, x.dom});
        chk("err_multi",  x.step, {7'd0, err_multi},  {7'd0, x.multi});
        chk("err_sticky", x.step, {5'd0, err_sticky}, {5'd0, x.sticky});
        chk("err_cnt",    x.step, {6'd0, err_cnt},    {6'd0, x.cnt});
      end
    end
  end

  initial begin : driver
    errors = 0; checks = 0; step_no = 0;
    rst = 1'b1; en = 1'b0; load = 1'b0; din = '0;
    inj_a = '0; inj_b = '0; inj_c = '0; err_clr = 1'b0;

    //    rst en ld din    inj_a  inj_b  inj_c  clr  dout   dom     m  sticky  cnt
    step(1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0,   8'h00, 3'b000, 0, 3'b000, 2'd0);
    step(1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0,   8'h00, 3'b000, 0, 3'b000, 2'd0);
    step(0, 0, 1, 8'hA5, 8'h00, 8'h00, 8'h00, 0,   8'hA5, 3'b000, 0, 3'b000, 2'd0);
    step(0, 1, 0, 8'h0F, 8'h00, 8'h00, 8'h00, 0,   8'hAA, 3'b000, 0, 3'b000, 2'd0);
    step(0, 1, 0, 8'h0F, 8'h00, 8'h00, 8'h00, 0,   8'hA5, 3'b000, 0, 3'b000, 2'd0);
    step(0, 0, 0, 8'h0F, 8'h00, 8'h00, 8'h00, 0,   8'hA5, 3'b000, 0, 3'b000, 2'd0);
    // single-domain upset on B, then scrubbed
    step(0, 0, 0, 8'h00, 8'h00, 8'h01, 8'h00, 0,   8'hA5, 3'b010, 0, 3'b000, 2'd0);
    step(0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0,   8'hA5, 3'b000, 0, 3'b010, 2'd1);
    step(0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0,   8'hA5, 3'b000, 0, 3'b010, 2'd1);
    // identical same-bit corruption of A and C outvotes B
    step(0, 0, 0, 8'h00, 8'h80, 8'h00, 8'h80, 0,   8'h25, 3'b010, 0, 3'b010, 2'd1);
    // different-bit corruption of A and C: multi flagged, vote intact
    step(0, 0, 0, 8'h00, 8'h01, 8'h00, 8'h02, 0,   8'h25, 3'b101, 1, 3'b010, 2'd2);
    step(0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0,   8'h25, 3'b000, 0, 3'b111, 2'd3);
    step(0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0,   8'h25, 3'b000, 0, 3'b111, 2'd3);
    step(0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1,   8'h25, 3'b000, 0, 3'b000, 2'd0);
    // five consecutive upsets on A: counter saturates at 3
    step(0, 0, 0, 8'h00, 8'h01, 8'h00, 8'h00, 0,   8'h25, 3'b001, 0, 3'b000, 2'd0);
    step(0, 0, 0, 8'h00, 8'h01, 8'h00, 8'h00, 0,   8'h25, 3'b001, 0, 3'b001, 2'd1);
    step(0, 0, 0, 8'h00, 8'h01, 8'h00, 8'h00, 0,   8'h25, 3'b001, 0, 3'b001, 2'd2);
    step(0, 0, 0, 8'h00, 8'h01, 8'h00, 8'h00, 0,   8'h25, 3'b001, 0, 3'b001, 2'd3);
    step(0, 0, 0, 8'h00, 8'h01, 8'h00, 8'h00, 0,   8'h25, 3'b001, 0, 3'b001, 2'd3);
    step(0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0,   8'h25, 3'b000, 0, 3'b001, 2'd3);
    // clear during a mismatch cycle wins over the increment
    step(0, 0, 0, 8'h00, 8'h01, 8'h00, 8'h00, 0,   8'h25, 3'b001, 0, 3'b001, 2'd3);
    step(0, 0, 0, 8'h00, 8'h01, 8'h00, 8'h00, 1,   8'h25, 3'b001, 0, 3'b000, 2'd0);
    step(0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0,   8'h25, 3'b000, 0, 3'b001, 2'd1);
    // reset mid-accumulate with injection active
    step(1, 1, 0, 8'hFF, 8'h00, 8'h00, 8'hF0, 0,   8'h00, 3'b000, 0, 3'b000, 2'd0);
    step(0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0,   8'h00, 3'b000, 0, 3'b000, 2'd0);
    step(0, 1, 0, 8'h3C, 8'h00, 8'h00, 8'h00, 0,   8'h3C, 3'b000, 0, 3'b000, 2'd0);

    @(negedge clk);
    rst = 1'b0; en = 1'b0; load = 1'b0; din = '0;
    inj_a = '0; inj_b = '0; inj_c = '0; err_clr = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
